// File: rtl/mem_arb_pkg.sv
// Shared types for the round-robin memory arbiter: RAM status, request kind and FSM state.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    INSTR  = 2'd0,
    DREAD  = 2'd1,
    DWRITE = 2'd2
  } req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for n ports; a single port still needs a 1-bit index.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// Cache-side and RAM-side bus of the arbiter; slave = arbiter, master = caches/RAM environment.
interface mem_arbiter_rr_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
) ();

  logic [CPUS-1:0]        iREN;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*ADDR_W-1:0] iaddr;
  logic [CPUS*ADDR_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS*WORD_W-1:0] dload;
  logic [CPUS-1:0]        derr;
  logic [ADDR_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic                   ramREN;
  logic                   ramWEN;
  logic [WORD_W-1:0]      ramload;
  ramstate_t              ramstate;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, derr, ramaddr, ramstore, ramREN, ramWEN
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, derr, ramaddr, ramstore, ramREN, ramWEN
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping modulo CPUS.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned CPUS = 2,
  localparam int unsigned IdxW = idx_width(CPUS)
) (
  input  logic [CPUS-1:0] req,
  input  logic [IdxW-1:0] rr_ptr,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  int unsigned     k;
  logic [IdxW-1:0] kidx;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    kidx  = '0;
    for (int unsigned off = 0; off < CPUS; off++) begin
      k = 32'(rr_ptr) + off;
      if (k >= CPUS) k = k - CPUS;
      kidx = IdxW'(k);
      if (!valid && req[kidx]) begin
        valid = 1'b1;
        idx   = kidx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter of per-CPU I/D cache requests onto one RAM port.
// Optional per-CPU completion and stall counters under MEM_ARBITER_STATS_EN.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int unsigned CPUS   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  mem_arbiter_rr_if.slave      bus
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [CPUS*16-1:0]   grant_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int unsigned IdxW = idx_width(CPUS);

  arb_state_t      state_q, state_d;
  req_t            gnt_type_q, gnt_type_d;
  logic [IdxW-1:0] gnt_cpu_q, gnt_cpu_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] pick_idx;
  logic            pick_valid;
  logic [CPUS-1:0] any_req;
  logic            req_live;
  logic            done;

  assign any_req = bus.iREN | bus.dREN | bus.dWEN;

  rr_picker #(.CPUS(CPUS)) u_picker (
    .req    (any_req),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // The granted line must stay high; dropping it aborts the transfer.
  always_comb begin
    req_live = 1'b0;
    unique case (gnt_type_q)
      INSTR:   req_live = bus.iREN[gnt_cpu_q];
      DREAD:   req_live = bus.dREN[gnt_cpu_q];
      default: req_live = bus.dWEN[gnt_cpu_q];
    endcase
  end

  assign done = (state_q == GRANT) && req_live &&
                ((bus.ramstate == ACCESS) || (bus.ramstate == ERROR));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      gnt_type_q <= INSTR;
      gnt_cpu_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_type_q <= gnt_type_d;
      gnt_cpu_q  <= gnt_cpu_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_type_d = gnt_type_q;
    gnt_cpu_d  = gnt_cpu_q;
    rr_ptr_d   = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d   = GRANT;
          gnt_cpu_d = pick_idx;
          if (bus.dWEN[pick_idx])      gnt_type_d = DWRITE;
          else if (bus.dREN[pick_idx]) gnt_type_d = DREAD;
          else                         gnt_type_d = INSTR;
        end
      end
      GRANT: begin
        if (!req_live) begin
          state_d = IDLE;
        end else if (done) begin
          state_d  = IDLE;
          rr_ptr_d = (32'(gnt_cpu_q) == CPUS - 1) ? '0 : gnt_cpu_q + IdxW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.derr     = '0;
    if ((state_q == GRANT) && req_live) begin
      if (gnt_type_q == INSTR) begin
        bus.ramaddr = bus.iaddr[32'(gnt_cpu_q)*ADDR_W +: ADDR_W];
        bus.ramREN  = 1'b1;
      end else begin
        bus.ramaddr = bus.daddr[32'(gnt_cpu_q)*ADDR_W +: ADDR_W];
        bus.ramREN  = (gnt_type_q == DREAD);
        bus.ramWEN  = (gnt_type_q == DWRITE);
        if (gnt_type_q == DWRITE) bus.ramstore = bus.dstore[32'(gnt_cpu_q)*WORD_W +: WORD_W];
      end
      if (done) begin
        if (gnt_type_q == INSTR) begin
          bus.iwait[gnt_cpu_q]                     = 1'b0;
          bus.iload[32'(gnt_cpu_q)*WORD_W +: WORD_W] = bus.ramload;
        end else begin
          bus.dwait[gnt_cpu_q]                     = 1'b0;
          bus.dload[32'(gnt_cpu_q)*WORD_W +: WORD_W] = bus.ramload;
          bus.derr[gnt_cpu_q]                      = (bus.ramstate == ERROR);
        end
      end
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  logic [CPUS-1:0][15:0] grant_cnt_q;
  logic [15:0]           stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (done && (grant_cnt_q[gnt_cpu_q] != 16'hFFFF)) begin
        grant_cnt_q[gnt_cpu_q] <= grant_cnt_q[gnt_cpu_q] + 16'd1;
      end
      if ((state_q == GRANT) && (bus.ramstate == BUSY) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with CPUS=2; stats checks compile in with MEM_ARBITER_STATS_EN.
module tb_mem_arbiter_rr;
  import mem_arb_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 CLK = ~CLK;

  mem_arbiter_rr_if #(.CPUS(2), .ADDR_W(32), .WORD_W(32)) bus ();

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] grant_cnt;
  logic [15:0] stall_cnt;
`endif

  mem_arbiter_rr #(.CPUS(2), .ADDR_W(32), .WORD_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN     = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_inputs();
    bus.iREN = 2'b11; bus.dREN = 2'b11; bus.dWEN = 2'b11;
    bus.daddr[31:0] = 32'h0000_0AA0;
    bus.ramstate = ACCESS;
    tick();
    tick();
    vec_cnt++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
      err_cnt++; $display("FAIL reset_en: got ren=%b wen=%b want 0 0", bus.ramREN, bus.ramWEN);
    end
    vec_cnt++;
    if (bus.iwait !== 2'b11 || bus.dwait !== 2'b11) begin
      err_cnt++; $display("FAIL reset_wait: got i=%b d=%b want 11 11", bus.iwait, bus.dwait);
    end
    vec_cnt++;
    if (bus.derr !== 2'b00 || bus.dload !== '0 || bus.iload !== '0) begin
      err_cnt++; $display("FAIL reset_derr_load: got derr=%b dload=%h iload=%h want 0", bus.derr,
                          bus.dload, bus.iload);
    end
    vec_cnt++;
    if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin
      err_cnt++; $display("FAIL reset_bus: got addr=%h store=%h want 0 0", bus.ramaddr,
                          bus.ramstore);
    end
    RST = 1'b0;
    #1;
    vec_cnt++;
    if (bus.ramWEN !== 1'b0) begin
      err_cnt++; $display("FAIL reset_release_idle: got wen=%b want 0", bus.ramWEN);
    end
    tick();
    vec_cnt++;
    if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h0000_0AA0) begin
      err_cnt++; $display("FAIL reset_first_grant: got wen=%b addr=%h want 1 00000aa0", bus.ramWEN,
                          bus.ramaddr);
    end
  endtask

  task automatic test_single_read();
    int   ren_n = 0;
    int   lo_n  = 0;
    int   other_n = 0;
    logic drop = 1'b0;
    logic [31:0] got_load = '0;
    logic [31:0] got_addr = '0;
    do_reset();
    bus.iREN = 2'b10;
    bus.iaddr[63:32] = 32'h40;
    bus.ramload = 32'hDEAD_BEEF;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (drop) bus.iREN = 2'b00;
      if (bus.ramREN) begin
        got_addr = bus.ramaddr;
        bus.ramstate = (ren_n < 2) ? BUSY : ACCESS;
        ren_n++;
      end else begin
        bus.ramstate = FREE;
      end
      #1;
      if (bus.iwait[1] === 1'b0) begin
        lo_n++;
        got_load = bus.iload[63:32];
        drop = 1'b1;
      end
      if (bus.iwait[0] !== 1'b1 || bus.dwait !== 2'b11) other_n++;
    end
    vec_cnt++;
    if (ren_n != 3) begin err_cnt++; $display("FAIL single_ren_cycles: got %0d want 3", ren_n); end
    vec_cnt++;
    if (lo_n != 1) begin err_cnt++; $display("FAIL single_iwait_low: got %0d want 1", lo_n); end
    vec_cnt++;
    if (got_load !== 32'hDEAD_BEEF) begin
      err_cnt++; $display("FAIL single_iload: got %h want deadbeef", got_load);
    end
    vec_cnt++;
    if (got_addr !== 32'h40) begin
      err_cnt++; $display("FAIL single_addr: got %h want 00000040", got_addr);
    end
    vec_cnt++;
    if (other_n != 0) begin
      err_cnt++; $display("FAIL single_other_waits: got %0d low cycles want 0", other_n);
    end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_w;
    logic [31:0] exp_a;
    do_reset();
    bus.dREN = 2'b11;
    bus.daddr[31:0]  = 32'h100;
    bus.daddr[63:32] = 32'h200;
    bus.ramstate = ACCESS;
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_w = 2'b11;
      exp_a = 32'h0;
      if (c % 2 == 0) begin
        exp_w = ((c / 2) % 2 == 0) ? 2'b10 : 2'b01;
        exp_a = ((c / 2) % 2 == 0) ? 32'h100 : 32'h200;
      end
      vec_cnt++;
      if (bus.dwait !== exp_w || bus.ramaddr !== exp_a) begin
        err_cnt++; $display("FAIL fair_cycle%0d: got dwait=%b addr=%h want %b %h", c, bus.dwait,
                            bus.ramaddr, exp_w, exp_a);
      end
    end
  endtask

  task automatic test_priority();
    req_t        ops[3];
    int          op_n = 0;
    logic        drop_w = 1'b0, drop_r = 1'b0, drop_i = 1'b0;
    logic [31:0] first_addr = '0, first_store = '0;
    do_reset();
    bus.iREN = 2'b01; bus.dREN = 2'b01; bus.dWEN = 2'b01;
    bus.daddr[31:0]  = 32'h80;
    bus.dstore[31:0] = 32'h1234;
    bus.iaddr[31:0]  = 32'h500;
    bus.ramstate = ACCESS;
    for (int i = 0; i < 3; i++) ops[i] = FREE == FREE ? INSTR : INSTR;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (drop_w) begin bus.dWEN[0] = 1'b0; drop_w = 1'b0; end
      if (drop_r) begin bus.dREN[0] = 1'b0; drop_r = 1'b0; end
      if (drop_i) begin bus.iREN[0] = 1'b0; drop_i = 1'b0; end
      #1;
      if (bus.ramWEN || bus.ramREN) begin
        if (op_n < 3) ops[op_n] = bus.ramWEN ? DWRITE : ((bus.ramaddr == 32'h500) ? INSTR : DREAD);
        if (op_n == 0) begin first_addr = bus.ramaddr; first_store = bus.ramstore; end
        op_n++;
        if (bus.dwait[0] === 1'b0) begin
          if (bus.ramWEN) drop_w = 1'b1;
          else            drop_r = 1'b1;
        end
        if (bus.iwait[0] === 1'b0) drop_i = 1'b1;
      end
    end
    vec_cnt++;
    if (op_n != 3) begin err_cnt++; $display("FAIL prio_op_count: got %0d want 3", op_n); end
    vec_cnt++;
    if (ops[0] != DWRITE || first_addr !== 32'h80 || first_store !== 32'h1234) begin
      err_cnt++; $display("FAIL prio_first_write: got op=%0d addr=%h store=%h want 2 80 1234",
                          ops[0], first_addr, first_store);
    end
    vec_cnt++;
    if (ops[1] != DREAD || ops[2] != INSTR) begin
      err_cnt++; $display("FAIL prio_order: got %0d,%0d want 1,0", ops[1], ops[2]);
    end
  endtask

  task automatic test_abort();
    do_reset();
    bus.dREN = 2'b01;
    bus.daddr[31:0]  = 32'h300;
    bus.daddr[63:32] = 32'h400;
    bus.ramstate = BUSY;
    tick();
    vec_cnt++;
    if (bus.ramREN !== 1'b1) begin err_cnt++; $display("FAIL abort_grant: got %b want 1", bus.ramREN); end
    tick();
    bus.dREN = 2'b00;
    #1;
    vec_cnt++;
    if (bus.ramREN !== 1'b0 || bus.dwait !== 2'b11) begin
      err_cnt++; $display("FAIL abort_drop: got ren=%b dwait=%b want 0 11", bus.ramREN, bus.dwait);
    end
    tick();
    vec_cnt++;
    if (bus.ramREN !== 1'b0) begin err_cnt++; $display("FAIL abort_idle: got %b want 0", bus.ramREN); end
    bus.dREN = 2'b11;
    bus.ramstate = ACCESS;
    tick();
    vec_cnt++;
    if (bus.ramaddr !== 32'h300 || bus.dwait !== 2'b10) begin
      err_cnt++; $display("FAIL abort_rr_kept: got addr=%h dwait=%b want 300 10", bus.ramaddr,
                          bus.dwait);
    end
  endtask

  task automatic test_error();
    do_reset();
    bus.dWEN = 2'b10;
    bus.daddr[63:32]  = 32'h600;
    bus.dstore[63:32] = 32'hCAFE;
    bus.ramstate = ERROR;
    tick();
    vec_cnt++;
    if (bus.ramWEN !== 1'b1 || bus.ramstore !== 32'hCAFE || bus.ramaddr !== 32'h600) begin
      err_cnt++; $display("FAIL err_write_bus: got wen=%b store=%h addr=%h want 1 cafe 600",
                          bus.ramWEN, bus.ramstore, bus.ramaddr);
    end
    vec_cnt++;
    if (bus.derr !== 2'b10 || bus.dwait !== 2'b01) begin
      err_cnt++; $display("FAIL err_pulse: got derr=%b dwait=%b want 10 01", bus.derr, bus.dwait);
    end
    tick();
    bus.dWEN = 2'b00;
    #1;
    vec_cnt++;
    if (bus.derr !== 2'b00 || bus.dwait !== 2'b11) begin
      err_cnt++; $display("FAIL err_one_cycle: got derr=%b dwait=%b want 00 11", bus.derr,
                          bus.dwait);
    end
    bus.iREN = 2'b01;
    tick();
    vec_cnt++;
    if (bus.iwait !== 2'b10 || bus.derr !== 2'b00 || bus.ramREN !== 1'b1) begin
      err_cnt++; $display("FAIL err_instr_silent: got iwait=%b derr=%b ren=%b want 10 00 1",
                          bus.iwait, bus.derr, bus.ramREN);
    end
    tick();
    bus.iREN = 2'b00;
  endtask

`ifdef MEM_ARBITER_STATS_EN
  task automatic test_stats();
    int plan[3] = '{2, 2, 0};
    int xfer = 0;
    int busy_used = 0;
    do_reset();
    bus.dREN = 2'b01;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (xfer >= 3) bus.dREN = 2'b00;
      #1;
      if (bus.ramREN && xfer < 3) begin
        if (busy_used < plan[xfer]) begin
          bus.ramstate = BUSY; busy_used++;
        end else begin
          bus.ramstate = ACCESS; xfer++; busy_used = 0;
        end
      end else begin
        bus.ramstate = FREE;
      end
    end
    vec_cnt++;
    if (grant_cnt !== {16'd0, 16'd3}) begin
      err_cnt++; $display("FAIL stats_grant: got %h want 00000003", grant_cnt);
    end
    vec_cnt++;
    if (stall_cnt !== 16'd4) begin
      err_cnt++; $display("FAIL stats_stall: got %0d want 4", stall_cnt);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_fairness();
    test_priority();
    test_abort();
    test_error();
`ifdef MEM_ARBITER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
